keypad_decoder: RTL and testbench
=================================

KEYPAD_DECODER -- requirements
Module: keypad_decoder

Interface
REQ-001 Parameter: RELEASE_CYCLES, default 4, number of consecutive cycles with enable low before a press is considered released.
REQ-002 Parameter: REPEAT_CYCLES, default 1000, hold time in cycles before auto-repeat; used only when KEYDEC_AUTOREPEAT_EN is defined.
REQ-003 Port: clk  in  1  system clock; all logic is on the rising edge.
REQ-004 Port: reset  in  1  synchronous, active-high reset.
REQ-005 Port: rows  in  4  row drive from the scanner; one-hot active-high; 4'b1000 = row1 ... 4'b0001 = row4.
REQ-006 Port: debounced_col  in  4  debounced columns; one-cold active-low; 4'b0111 = col0 ... 4'b1110 = col3.
REQ-007 Port: enable  in  1  scanner key-detected flag; held high while a key is stable-pressed.
REQ-008 Port: key_code  out  4  hex code of the last registered key.
REQ-009 Port: key_valid  out  1  single-cycle pulse for each registered key.
REQ-010 Port: digit_new  out  4  most recent registered key code.
REQ-011 Port: digit_old  out  4  previous registered key code.
REQ-012 Port: key_held  out  1  high while the FSM is in HELD.

Function
REQ-013 Key map (row, col0..col3): row1 = 1,2,3,A; row2 = 4,5,6,B; row3 = 7,8,9,C; row4 = E,0,F,D.
REQ-014 Decode valid only if rows is exactly one-hot and debounced_col has exactly one zero; any other pattern is invalid.
REQ-015 FSM states: IDLE, HELD, RELEASE.
REQ-016 IDLE: enable=1 with a valid decode -> register the key and go to HELD; enable=1 with an invalid decode -> stay in IDLE with no output change.
REQ-017 Registering a key, in the same clock edge: key_code <= code; digit_old <= digit_new; digit_new <= code; key_valid = 1 for exactly one cycle.
REQ-018 Latency: key_valid and the updated outputs are visible 1 cycle after the edge where enable=1 and the decode are sampled.
REQ-019 HELD: enable=1 -> stay, no registration, even if the decoded key changes (roll-over is ignored); enable=0 -> RELEASE with the release counter = 1.
REQ-020 RELEASE: enable=0 -> increment the counter; counter reaching RELEASE_CYCLES -> IDLE.
REQ-021 RELEASE: enable=1 before the count completes -> HELD with the counter cleared and no new registration (bounce suppression).
REQ-022 key_held = 1 in HELD and RELEASE; 0 in IDLE.
REQ-023 A new press is registered only from IDLE, giving at most one key_valid per physical press.
REQ-024 Counter width = clog2 of the larger of RELEASE_CYCLES and REPEAT_CYCLES, plus 1; the counter saturates and never wraps.

Reset
REQ-025 reset=1 at a clock edge: FSM -> IDLE; key_code, digit_new, digit_old = 4'h0; key_valid = 0; key_held = 0; counters = 0.
REQ-026 Reset overrides all other inputs, including mid-HELD or mid-RELEASE; no key_valid pulse is emitted in the cycle after reset.
REQ-027 First press after reset: digit_old = 4'h0.

Configuration
REQ-028 Macro KEYDEC_AUTOREPEAT_EN defined: in HELD with enable=1 and a valid decode, a hold counter runs; at REPEAT_CYCLES it re-registers the current code per REQ-017, then restarts the count; the counter clears on leaving HELD.
REQ-029 Macro KEYDEC_AUTOREPEAT_EN undefined: no hold counter is built; a held key never re-registers.

Verification
REQ-030 Reset, then idle with enable=0 for 200 cycles -> key_valid never asserts; digit_new = digit_old = 4'h0; key_held = 0.
REQ-031 rows=4'b1000, col=4'b0111, enable=1 for 20 cycles, then enable=0 -> exactly one key_valid; key_code = 4'h1; digit_new = 4'h1; digit_old = 4'h0.
REQ-032 Press row4/col3 (4'b0001/4'b1110), release, then press row2/col0 (4'b0100/4'b0111) -> codes 4'hD then 4'h4; final digit_new = 4'h4, digit_old = 4'hD.
REQ-033 During HELD, drop enable for 2 cycles (< RELEASE_CYCLES) then raise it -> no second key_valid; key_held stays 1 throughout.
REQ-034 enable=1 with rows=4'b1100 or col=4'b0011 -> no key_valid; FSM stays in IDLE; a later valid press still registers.
REQ-035 Assert reset during HELD -> key_held = 0 and digits = 0 on the next cycle; with KEYDEC_AUTOREPEAT_EN and REPEAT_CYCLES=10, holding '5' for 35 cycles -> 1 initial + 3 repeat pulses.

Source files
------------

// File: rtl/keypad_decoder.sv
// -----------------------------------------------------------------------------
// keypad_decoder
//   Turns the output of a 4x4 keypad scanner into hex key codes. A press is
//   registered once, when the scanner first reports a stable key with a clean
//   decode. A release counter requires a run of idle cycles before the next
//   press may register, which suppresses contact bounce and roll-over.
//
//   Optional feature: define KEYDEC_AUTOREPEAT_EN to build a hold counter
//   that re-registers a held key every REPEAT_CYCLES cycles.
//
// Parameters
//   RELEASE_CYCLES  consecutive enable-low cycles that end a press
//   REPEAT_CYCLES   auto-repeat period (only with KEYDEC_AUTOREPEAT_EN)
//
// Ports
//   clk            system clock, rising edge
//   reset          synchronous, active-high reset
//   rows[3:0]      one-hot row drive, 4'b1000 = row1 .. 4'b0001 = row4
//   debounced_col  one-cold columns, 4'b0111 = col0 .. 4'b1110 = col3
//   enable         scanner key-detected flag
//   key_code       code of the last registered key
//   key_valid      one-cycle pulse per registered key
//   digit_new      most recent registered code
//   digit_old      previous registered code
//   key_held       high while a press is active (HELD or RELEASE)
// -----------------------------------------------------------------------------
module keypad_decoder #(
  parameter int unsigned RELEASE_CYCLES = 4,
  parameter int unsigned REPEAT_CYCLES  = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows,
  input  logic [3:0] debounced_col,
  input  logic       enable,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic [3:0] digit_new,
  output logic [3:0] digit_old,
  output logic       key_held
);

  localparam int unsigned MAX_CYC = (RELEASE_CYCLES > REPEAT_CYCLES) ? RELEASE_CYCLES
                                                                      : REPEAT_CYCLES;
  localparam int unsigned CW = $clog2(MAX_CYC) + 1;

  localparam logic [CW-1:0] REL_LIMIT = CW'(RELEASE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_MAX   = '1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HELD,
    ST_RELEASE
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] rel_cnt_q, rel_cnt_d;
  logic [3:0]    key_code_q, key_code_d;
  logic          key_valid_q, key_valid_d;
  logic [3:0]    digit_new_q, digit_new_d;
  logic [3:0]    digit_old_q, digit_old_d;

`ifdef KEYDEC_AUTOREPEAT_EN
  localparam logic [CW-1:0] REP_LIMIT = CW'(REPEAT_CYCLES);
  logic [CW-1:0] hold_cnt_q, hold_cnt_d;
`endif

  // ---------------------------------------------------------------------------
  // Decode: row and column must each select exactly one line.
  // ---------------------------------------------------------------------------
  logic [1:0] row_idx, col_idx;
  logic       row_ok, col_ok, dec_valid;
  logic [3:0] dec_code;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so that
    // no path leaves it unassigned, which would infer a latch.
    row_idx  = 2'd0;
    col_idx  = 2'd0;
    row_ok   = 1'b1;
    col_ok   = 1'b1;
    dec_code = 4'h0;

    unique case (rows)
      4'b1000: row_idx = 2'd0;
      4'b0100: row_idx = 2'd1;
      4'b0010: row_idx = 2'd2;
      4'b0001: row_idx = 2'd3;
      default: row_ok  = 1'b0;
    endcase

    unique case (debounced_col)
      4'b0111: col_idx = 2'd0;
      4'b1011: col_idx = 2'd1;
      4'b1101: col_idx = 2'd2;
      4'b1110: col_idx = 2'd3;
      default: col_ok  = 1'b0;
    endcase

    // Printed legend of the keypad, row-major.
    unique case ({row_idx, col_idx})
      4'd0:  dec_code = 4'h1;
      4'd1:  dec_code = 4'h2;
      4'd2:  dec_code = 4'h3;
      4'd3:  dec_code = 4'hA;
      4'd4:  dec_code = 4'h4;
      4'd5:  dec_code = 4'h5;
      4'd6:  dec_code = 4'h6;
      4'd7:  dec_code = 4'hB;
      4'd8:  dec_code = 4'h7;
      4'd9:  dec_code = 4'h8;
      4'd10: dec_code = 4'h9;
      4'd11: dec_code = 4'hC;
      4'd12: dec_code = 4'hE;
      4'd13: dec_code = 4'h0;
      4'd14: dec_code = 4'hF;
      default: dec_code = 4'hD;
    endcase
  end

  assign dec_valid = row_ok && col_ok;

  // ---------------------------------------------------------------------------
  // Next-state and output logic.
  // ---------------------------------------------------------------------------
  logic do_reg;

  always_comb begin
    state_d   = state_q;
    rel_cnt_d = rel_cnt_q;
    do_reg    = 1'b0;
`ifdef KEYDEC_AUTOREPEAT_EN
    hold_cnt_d = hold_cnt_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        rel_cnt_d = '0;
        // An invalid decode is ignored outright; the scanner will re-report.
        if (enable && dec_valid) begin
          do_reg  = 1'b1;
          state_d = ST_HELD;
        end
      end

      ST_HELD: begin
        if (!enable) begin
          // The first low cycle already counts toward release.
          if (REL_LIMIT <= CNT_ONE) begin
            state_d   = ST_IDLE;
            rel_cnt_d = '0;
          end else begin
            state_d   = ST_RELEASE;
            rel_cnt_d = CNT_ONE;
          end
        end
`ifdef KEYDEC_AUTOREPEAT_EN
        else if (dec_valid) begin
          if (hold_cnt_q + CNT_ONE >= REP_LIMIT) begin
            do_reg     = 1'b1;
            hold_cnt_d = '0;
          end else begin
            hold_cnt_d = hold_cnt_q + CNT_ONE;
          end
        end
`endif
      end

      ST_RELEASE: begin
        if (enable) begin
          // Bounce: resume the same press without registering again.
          state_d   = ST_HELD;
          rel_cnt_d = '0;
        end else begin
          if (rel_cnt_q != CNT_MAX) rel_cnt_d = rel_cnt_q + CNT_ONE;
          if (rel_cnt_d >= REL_LIMIT) begin
            state_d   = ST_IDLE;
            rel_cnt_d = '0;
          end
        end
      end

      default: begin
        state_d   = ST_IDLE;
        rel_cnt_d = '0;
      end
    endcase

`ifdef KEYDEC_AUTOREPEAT_EN
    if (state_d != ST_HELD) hold_cnt_d = '0;
`endif

    key_valid_d = do_reg;
    key_code_d  = key_code_q;
    digit_new_d = digit_new_q;
    digit_old_d = digit_old_q;
    if (do_reg) begin
      key_code_d  = dec_code;
      digit_old_d = digit_new_q;
      digit_new_d = dec_code;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state_q     <= ST_IDLE;
      rel_cnt_q   <= '0;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
      digit_new_q <= 4'h0;
      digit_old_q <= 4'h0;
`ifdef KEYDEC_AUTOREPEAT_EN
      hold_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      rel_cnt_q   <= rel_cnt_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      digit_new_q <= digit_new_d;
      digit_old_q <= digit_old_d;
`ifdef KEYDEC_AUTOREPEAT_EN
      hold_cnt_q  <= hold_cnt_d;
`endif
    end
  end

  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign digit_new = digit_new_q;
  assign digit_old = digit_old_q;
  assign key_held  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_keypad_decoder.sv
// -----------------------------------------------------------------------------
// tb_keypad_decoder
//   Directed testbench for keypad_decoder. Inputs change on the falling edge;
//   outputs are sampled on the falling edge, half a cycle after the DUT edge.
//   key_valid pulses are counted 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_keypad_decoder;

  localparam int unsigned RELEASE_CYCLES = 4;
  localparam int unsigned REPEAT_CYCLES  = 10;

  logic       clk;
  logic       reset;
  logic [3:0] rows;
  logic [3:0] debounced_col;
  logic       enable;
  logic [3:0] key_code;
  logic       key_valid;
  logic [3:0] digit_new;
  logic [3:0] digit_old;
  logic       key_held;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int pulse_cnt = 0;

  keypad_decoder #(
    .RELEASE_CYCLES(RELEASE_CYCLES),
    .REPEAT_CYCLES (REPEAT_CYCLES)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rows         (rows),
    .debounced_col(debounced_col),
    .enable       (enable),
    .key_code     (key_code),
    .key_valid    (key_valid),
    .digit_new    (digit_new),
    .digit_old    (digit_old),
    .key_held     (key_held)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    #1;
    if (key_valid === 1'b1) pulse_cnt++;
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    enable = 1'b0;
    cycles(2);
    reset  = 1'b0;
    cycles(1);
  endtask

  // Hold a key for hold_cyc cycles, then release long enough to reach IDLE.
  task automatic press(input logic [3:0] r, input logic [3:0] c, input int hold_cyc);
    rows          = r;
    debounced_col = c;
    enable        = 1'b1;
    cycles(hold_cyc);
    enable        = 1'b0;
    cycles(RELEASE_CYCLES + 2);
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; rows = 4'b0000; debounced_col = 4'b1111;
    cycles(3);
    total_cnt++; if (key_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", key_valid); else pass_cnt++;
    total_cnt++; if (key_held !== 1'b0) $display("FAIL reset_held: got %b want 0", key_held); else pass_cnt++;
    total_cnt++; if (key_code !== 4'h0) $display("FAIL reset_code: got %h want 0", key_code); else pass_cnt++;
    total_cnt++; if (digit_new !== 4'h0 || digit_old !== 4'h0)
      $display("FAIL reset_digits: got %h/%h want 0/0", digit_new, digit_old); else pass_cnt++;
    reset = 1'b0;
    cycles(1);
  endtask

  task automatic test_idle();
    int p0;
    p0 = pulse_cnt;
    rows = 4'b1000; debounced_col = 4'b0111; enable = 1'b0;
    cycles(200);
    total_cnt++; if (pulse_cnt != p0) $display("FAIL idle_pulses: got %0d want 0", pulse_cnt - p0); else pass_cnt++;
    total_cnt++; if (digit_new !== 4'h0 || digit_old !== 4'h0)
      $display("FAIL idle_digits: got %h/%h want 0/0", digit_new, digit_old); else pass_cnt++;
    total_cnt++; if (key_held !== 1'b0) $display("FAIL idle_held: got %b want 0", key_held); else pass_cnt++;
  endtask

  task automatic test_single_press();
    int p0;
    p0 = pulse_cnt;
    rows = 4'b1000; debounced_col = 4'b0111; enable = 1'b1;
    cycles(1);
    total_cnt++; if (key_valid !== 1'b1) $display("FAIL single_latency: got %b want 1", key_valid); else pass_cnt++;
    total_cnt++; if (key_held !== 1'b1) $display("FAIL single_held: got %b want 1", key_held); else pass_cnt++;
    cycles(1);
    total_cnt++; if (key_valid !== 1'b0) $display("FAIL single_pulse_width: got %b want 0", key_valid); else pass_cnt++;
    cycles(18);
    enable = 1'b0;
    cycles(RELEASE_CYCLES + 2);
    total_cnt++; if (pulse_cnt - p0 != 1) $display("FAIL single_pulses: got %0d want 1", pulse_cnt - p0); else pass_cnt++;
    total_cnt++; if (key_code !== 4'h1) $display("FAIL single_code: got %h want 1", key_code); else pass_cnt++;
    total_cnt++; if (digit_new !== 4'h1 || digit_old !== 4'h0)
      $display("FAIL single_digits: got %h/%h want 1/0", digit_new, digit_old); else pass_cnt++;
    total_cnt++; if (key_held !== 1'b0) $display("FAIL single_released: got %b want 0", key_held); else pass_cnt++;
  endtask

  task automatic test_two_keys();
    int p0;
    p0 = pulse_cnt;
    press(4'b0001, 4'b1110, 5);
    total_cnt++; if (key_code !== 4'hD) $display("FAIL two_first_code: got %h want D", key_code); else pass_cnt++;
    press(4'b0100, 4'b0111, 5);
    total_cnt++; if (pulse_cnt - p0 != 2) $display("FAIL two_pulses: got %0d want 2", pulse_cnt - p0); else pass_cnt++;
    total_cnt++; if (digit_new !== 4'h4 || digit_old !== 4'hD)
      $display("FAIL two_digits: got %h/%h want 4/D", digit_new, digit_old); else pass_cnt++;
  endtask

  // Short enable drop plus a roll-over to another key while held.
  task automatic test_bounce();
    int  p0;
    bit  held_ok;
    p0 = pulse_cnt;
    held_ok = 1'b1;
    rows = 4'b0010; debounced_col = 4'b1011; enable = 1'b1;
    cycles(5);
    enable = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cycles(1);
      if (key_held !== 1'b1) held_ok = 1'b0;
    end
    enable = 1'b1;
    rows = 4'b0001; debounced_col = 4'b0111;
    for (int i = 0; i < 4; i++) begin
      cycles(1);
      if (key_held !== 1'b1) held_ok = 1'b0;
    end
    total_cnt++; if (!held_ok) $display("FAIL bounce_held: got dropped want steady 1"); else pass_cnt++;
    enable = 1'b0;
    cycles(RELEASE_CYCLES + 2);
    total_cnt++; if (pulse_cnt - p0 != 1) $display("FAIL bounce_pulses: got %0d want 1", pulse_cnt - p0); else pass_cnt++;
    total_cnt++; if (digit_new !== 4'h8 || digit_old !== 4'h4)
      $display("FAIL bounce_digits: got %h/%h want 8/4", digit_new, digit_old); else pass_cnt++;
  endtask

  task automatic test_invalid();
    int p0;
    p0 = pulse_cnt;
    press(4'b1100, 4'b0111, 5);
    press(4'b1000, 4'b0011, 5);
    press(4'b0000, 4'b1110, 5);
    press(4'b0100, 4'b1111, 5);
    total_cnt++; if (pulse_cnt != p0) $display("FAIL invalid_pulses: got %0d want 0", pulse_cnt - p0); else pass_cnt++;
    total_cnt++; if (digit_new !== 4'h8) $display("FAIL invalid_digit: got %h want 8", digit_new); else pass_cnt++;
    rows = 4'b1100; debounced_col = 4'b0111; enable = 1'b1;
    cycles(2);
    total_cnt++; if (key_held !== 1'b0) $display("FAIL invalid_idle: got %b want 0", key_held); else pass_cnt++;
    enable = 1'b0;
    cycles(1);
    press(4'b0001, 4'b1101, 3);
    total_cnt++; if (digit_new !== 4'hF || digit_old !== 4'h8)
      $display("FAIL invalid_recover: got %h/%h want F/8", digit_new, digit_old); else pass_cnt++;
  endtask

  task automatic test_keymap();
    logic [3:0] exp_tbl [16];
    logic [3:0] one_hot;
    logic [3:0] prev;
    exp_tbl = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};
    prev = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        one_hot = 4'b1000;
        press(one_hot >> r, ~(one_hot >> c), 2);
        total_cnt++;
        if (key_code !== exp_tbl[r*4+c] || digit_old !== prev)
          $display("FAIL keymap_r%0d_c%0d: got %h/%h want %h/%h", r, c,
                   key_code, digit_old, exp_tbl[r*4+c], prev);
        else pass_cnt++;
        prev = exp_tbl[r*4+c];
      end
    end
  endtask

  task automatic test_reset_mid_press();
    rows = 4'b0100; debounced_col = 4'b1011; enable = 1'b1;
    cycles(3);
    reset = 1'b1;
    cycles(1);
    total_cnt++; if (key_held !== 1'b0) $display("FAIL rst_held_held: got %b want 0", key_held); else pass_cnt++;
    total_cnt++; if (digit_new !== 4'h0 || digit_old !== 4'h0 || key_code !== 4'h0)
      $display("FAIL rst_held_digits: got %h/%h/%h want 0/0/0", key_code, digit_new, digit_old); else pass_cnt++;
    total_cnt++; if (key_valid !== 1'b0) $display("FAIL rst_held_valid: got %b want 0", key_valid); else pass_cnt++;
    reset = 1'b0;
    cycles(1);
    total_cnt++; if (key_valid !== 1'b1 || digit_new !== 4'h5 || digit_old !== 4'h0)
      $display("FAIL rst_first_press: got %b %h/%h want 1 5/0", key_valid, digit_new, digit_old); else pass_cnt++;
    enable = 1'b0;
    cycles(2);
    reset = 1'b1;
    cycles(1);
    reset = 1'b0;
    total_cnt++; if (key_held !== 1'b0 || digit_new !== 4'h0)
      $display("FAIL rst_release: got %b %h want 0 0", key_held, digit_new); else pass_cnt++;
    cycles(RELEASE_CYCLES + 2);
  endtask

  task automatic test_hold();
    int p0;
    int exp_pulses;
`ifdef KEYDEC_AUTOREPEAT_EN
    exp_pulses = 4;
`else
    exp_pulses = 1;
`endif
    do_reset();
    p0 = pulse_cnt;
    press(4'b0100, 4'b1011, 35);
    total_cnt++; if (pulse_cnt - p0 != exp_pulses)
      $display("FAIL hold_pulses: got %0d want %0d", pulse_cnt - p0, exp_pulses); else pass_cnt++;
    total_cnt++; if (digit_new !== 4'h5) $display("FAIL hold_digit: got %h want 5", digit_new); else pass_cnt++;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; rows = 4'b0000; debounced_col = 4'b1111;
    test_reset();
    test_idle();
    test_single_press();
    test_two_keys();
    test_bounce();
    test_invalid();
    test_keymap();
    test_reset_mid_press();
    test_hold();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
